// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types and constants for the AES decryption round logic.
// Build option INV_ROUND_QUAD_SBOX_EN selects the four-lane (one column per cycle)
// substitution schedule; without it one byte is substituted per cycle.
package aes_dec_pkg;

  localparam int unsigned NB_BYTES = 16;

`ifdef INV_ROUND_QUAD_SBOX_EN
  localparam int unsigned SUB_CYCLES = 4;
`else
  localparam int unsigned SUB_CYCLES = 16;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SUB  = 2'b01,
    ST_DONE = 2'b10
  } dec_state_e;

  // Source byte index for InvShiftRows: destination (row r, column c) reads
  // row r, column (c - r) mod 4. The 2-bit subtraction wraps the column.
  function automatic logic [3:0] inv_shift_src(input logic [3:0] k);
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] src_col;
    row     = k[1:0];
    col     = k[3:2];
    src_col = col - row;
    return {src_col, row};
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: combinational AES inverse S-box, 8-bit in, 8-bit out.
// Stand-alone so the key-schedule logic can reuse it.
module inv_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] inv_val
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign inv_val = INV_SBOX[byte_val];

endmodule

// File: rtl/inv_round_pre_mix.sv
// inv_round_pre_mix: decryption-round front end. InvShiftRows, InvSubBytes and
// AddRoundKey on a 128-bit column-major state, feeding the inverse-mix stage.
// Operands are latched on acceptance, then substituted a byte (or, with
// INV_ROUND_QUAD_SBOX_EN defined, a column) per cycle into the output register.
// One idle cycle separates consecutive blocks.
module inv_round_pre_mix
  import aes_dec_pkg::*;
#(
  parameter int unsigned ADD_KEY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic [0:127] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         out_last
);

  localparam int unsigned LANES    = NB_BYTES / SUB_CYCLES;
  localparam logic [3:0]  LAST_CNT = 4'(SUB_CYCLES - 1);

  dec_state_e   state_r;
  dec_state_e   state_s;
  logic [3:0]   cnt_r;
  logic [0:127] src_r;
  logic [0:127] key_r;

  logic [3:0] byte_idx_s [LANES];
  logic [7:0] sbox_in_s  [LANES];
  logic [7:0] sbox_out_s [LANES];
  logic [7:0] key_byte_s [LANES];

  // Substitution lanes: lane g handles destination byte cnt*LANES + g.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign byte_idx_s[g] = 4'(cnt_r * 4'(LANES) + 4'(g));
    assign sbox_in_s[g]  = src_r[{inv_shift_src(byte_idx_s[g]), 3'b000} +: 8];
    assign key_byte_s[g] = (ADD_KEY != 32'd0) ? key_r[{byte_idx_s[g], 3'b000} +: 8] : 8'h00;

    inv_sbox u_inv_sbox (
      .byte_val (sbox_in_s[g]),
      .inv_val  (sbox_out_s[g])
    );
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: accept in IDLE, substitute until the last count, hold DONE until taken
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_SUB;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SUB: begin
        if (cnt_r == LAST_CNT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SUB;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);

  // Operand capture, byte counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 4'd0;
      src_r     <= 128'd0;
      key_r     <= 128'd0;
      out_state <= 128'd0;
      out_last  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            src_r    <= in_state;
            key_r    <= in_key;
            out_last <= in_last;
            cnt_r    <= 4'd0;
          end
        end
        ST_SUB: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            out_state[{byte_idx_s[l], 3'b000} +: 8] <= sbox_out_s[l] ^ key_byte_s[l];
          end
          cnt_r <= (cnt_r == LAST_CNT) ? 4'd0 : cnt_r + 4'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_round_pre_mix.sv
// tb_inv_round_pre_mix: randomized self-checking bench for inv_round_pre_mix.
// Two instances share all inputs: one with ADD_KEY=1, one with ADD_KEY=0.
// The reference inverse S-box is derived from GF(2^8) inversion plus the AES
// affine map, independently of the RTL lookup table.
module tb_inv_round_pre_mix;

`ifdef INV_ROUND_QUAD_SBOX_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 16;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_last;
  logic         out_ready;
  logic [0:127] in_state;
  logic [0:127] in_key;

  logic         k1_in_ready, k1_out_valid, k1_out_last;
  logic [0:127] k1_out_state;
  logic         k0_in_ready, k0_out_valid, k0_out_last;
  logic [0:127] k0_out_state;

  int n_vec;
  int n_err;
  logic [7:0] inv_tab [256];

  inv_round_pre_mix #(.ADD_KEY(1)) dut_k1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(k1_in_ready),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(k1_out_valid), .out_ready(out_ready), .out_state(k1_out_state), .out_last(k1_out_last)
  );

  inv_round_pre_mix #(.ADD_KEY(0)) dut_k0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(k0_in_ready),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .out_valid(k0_out_valid), .out_ready(out_ready), .out_state(k0_out_state), .out_last(k0_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_tab();
    logic [7:0] b;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  // out(row r, col c) = InvSub(in(row r, col (c-r) mod 4)) ^ key(row r, col c)
  function automatic logic [0:127] ref_round(input logic [0:127] st, input logic [0:127] ky, input bit use_key);
    logic [0:127] res;
    int sc;
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = (c - r + 4) % 4;
        res[8*(r+4*c) +: 8] = inv_tab[st[8*(r+4*sc) +: 8]] ^ (use_key ? ky[8*(r+4*c) +: 8] : 8'h00);
      end
    end
    return res;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives one transaction from IDLE, records latency and results, then completes the handshake.
  task automatic do_txn(input logic [0:127] st, input logic [0:127] ky, input logic lst, input int stall,
                        output int lat, output logic [0:127] o1, output logic [0:127] o0,
                        output logic l1, output logic l0);
    int n;
    in_state = st; in_key = ky; in_last = lst; in_valid = 1'b1;
    n = 0;
    while (!k1_in_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_state = rnd128(); in_key = rnd128(); in_last = ~lst;
    lat = 0;
    while (!k1_out_valid && lat < 40) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    out_ready = 1'b0;
    o1 = k1_out_state; o0 = k0_out_state; l1 = k1_out_last; l0 = k0_out_last;
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (k1_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", k1_out_valid); end
    n_vec++; if (k1_out_state !== 128'd0) begin n_err++; $display("FAIL reset_out_state: got %h want 0", k1_out_state); end
    n_vec++; if (k1_out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", k1_out_last); end
    n_vec++; if (k1_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", k1_in_ready); end
    n_vec++; if (k0_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_k0_out_valid: got %b want 0", k0_out_valid); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    int lat; logic [0:127] o1, o0; logic l1, l0;
    do_txn(128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e, 1'b0, 2, lat, o1, o0, l1, l0);
    n_vec++; if (o1 !== 128'he9f74eec023020f61bf2ccf2353c21c7) begin n_err++; $display("FAIL fips_keyed: got %h want e9f74eec023020f61bf2ccf2353c21c7", o1); end
    n_vec++; if (o0 !== 128'hbd6e7c3df2b5779e0b61216e8b10b689) begin n_err++; $display("FAIL fips_unkeyed: got %h want bd6e7c3df2b5779e0b61216e8b10b689", o0); end
    n_vec++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL fips_latency: got %0d want %0d", lat, EXP_LAT); end
  endtask

  task automatic test_zero();
    int lat; logic [0:127] o1, o0; logic l1, l0;
    do_txn(128'd0, 128'd0, 1'b0, 0, lat, o1, o0, l1, l0);
    n_vec++; if (o1 !== {16{8'h52}}) begin n_err++; $display("FAIL zero_key0_keyed: got %h want all 52", o1); end
    n_vec++; if (o0 !== {16{8'h52}}) begin n_err++; $display("FAIL zero_key0_unkeyed: got %h want all 52", o0); end
    do_txn(128'd0, {16{8'hff}}, 1'b0, 1, lat, o1, o0, l1, l0);
    n_vec++; if (o0 !== {16{8'h52}}) begin n_err++; $display("FAIL zero_keyff_unkeyed: got %h want all 52", o0); end
    n_vec++; if (o1 !== {16{8'had}}) begin n_err++; $display("FAIL zero_keyff_keyed: got %h want all ad", o1); end
  endtask

  task automatic test_63();
    int lat; logic [0:127] o1, o0; logic l1, l0;
    do_txn({16{8'h63}}, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 0, lat, o1, o0, l1, l0);
    n_vec++; if (o1 !== 128'h000102030405060708090a0b0c0d0e0f) begin n_err++; $display("FAIL s63_keyed: got %h want 000102030405060708090a0b0c0d0e0f", o1); end
    n_vec++; if (o0 !== 128'd0) begin n_err++; $display("FAIL s63_unkeyed: got %h want 0", o0); end
    n_vec++; if (l1 !== 1'b1) begin n_err++; $display("FAIL s63_last: got %b want 1", l1); end
  endtask

  task automatic test_backpressure();
    logic [0:127] st, ky, exp1; int lat;
    st = rnd128(); ky = rnd128(); exp1 = ref_round(st, ky, 1'b1);
    in_state = st; in_key = ky; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!k1_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, EXP_LAT); end
    for (int i = 0; i < 10; i++) begin
      in_state = rnd128(); in_key = rnd128();
      @(posedge clk); #1;
      n_vec++;
      if (k1_out_valid !== 1'b1 || k1_in_ready !== 1'b0 || k1_out_state !== exp1) begin
        n_err++;
        $display("FAIL bp_hold cyc %0d: valid=%b in_ready=%b state=%h want valid=1 in_ready=0 state=%h", i, k1_out_valid, k1_in_ready, k1_out_state, exp1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (k1_in_ready !== 1'b1 || k1_out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: in_ready=%b valid=%b want in_ready=1 valid=0", k1_in_ready, k1_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] a, ka, b, kb; int edges, lat;
    a = rnd128(); ka = rnd128(); b = rnd128(); kb = rnd128();
    in_state = a; in_key = ka; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_state = b; in_key = kb; in_last = 1'b1;
    edges = 0;
    while (!k1_out_valid && edges < 40) begin @(posedge clk); #1; edges++; end
    n_vec++; if (k1_out_state !== ref_round(a, ka, 1'b1)) begin n_err++; $display("FAIL b2b_first_keyed: got %h want %h", k1_out_state, ref_round(a, ka, 1'b1)); end
    n_vec++; if (k0_out_state !== ref_round(a, ka, 1'b0)) begin n_err++; $display("FAIL b2b_first_unkeyed: got %h want %h", k0_out_state, ref_round(a, ka, 1'b0)); end
    n_vec++; if (k1_out_last !== 1'b0) begin n_err++; $display("FAIL b2b_first_last: got %b want 0", k1_out_last); end
    n_vec++; if (k1_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_ready: got %b want 0", k1_in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1; edges++;
    out_ready = 1'b0;
    n_vec++; if (k1_in_ready !== 1'b1 || k1_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_bubble: in_ready=%b valid=%b want 1 0", k1_in_ready, k1_out_valid); end
    @(posedge clk); #1; edges++;
    in_valid = 1'b0;
    n_vec++; if (k1_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: in_ready=%b want 0", k1_in_ready); end
    n_vec++; if (edges !== EXP_LAT + 2) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", edges, EXP_LAT + 2); end
    lat = 0;
    while (!k1_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, EXP_LAT); end
    n_vec++; if (k1_out_state !== ref_round(b, kb, 1'b1)) begin n_err++; $display("FAIL b2b_second_keyed: got %h want %h", k1_out_state, ref_round(b, kb, 1'b1)); end
    n_vec++; if (k0_out_state !== ref_round(b, kb, 1'b0)) begin n_err++; $display("FAIL b2b_second_unkeyed: got %h want %h", k0_out_state, ref_round(b, kb, 1'b0)); end
    n_vec++; if (k1_out_last !== 1'b1) begin n_err++; $display("FAIL b2b_second_last: got %b want 1", k1_out_last); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [0:127] st, ky, o1, o0; logic l1, l0;
    in_state = rnd128(); in_key = rnd128(); in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < ((EXP_LAT > 8) ? 7 : EXP_LAT - 1); i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_vec++; if (k1_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", k1_out_valid); end
    n_vec++; if (k1_out_state !== 128'd0) begin n_err++; $display("FAIL midrst_state: got %h want 0", k1_out_state); end
    n_vec++; if (k1_out_last !== 1'b0) begin n_err++; $display("FAIL midrst_last: got %b want 0", k1_out_last); end
    n_vec++; if (k1_in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", k1_in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    st = rnd128(); ky = rnd128();
    do_txn(st, ky, 1'b0, 0, lat, o1, o0, l1, l0);
    n_vec++; if (o1 !== ref_round(st, ky, 1'b1)) begin n_err++; $display("FAIL midrst_fresh: got %h want %h", o1, ref_round(st, ky, 1'b1)); end
    n_vec++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL midrst_latency: got %0d want %0d", lat, EXP_LAT); end
  endtask

  task automatic test_random();
    int lat; logic [0:127] st, ky, o1, o0; logic lst, l1, l0;
    for (int t = 0; t < 12; t++) begin
      st = rnd128(); ky = rnd128(); lst = 1'($urandom_range(0, 1));
      do_txn(st, ky, lst, $urandom_range(0, 3), lat, o1, o0, l1, l0);
      n_vec++; if (o1 !== ref_round(st, ky, 1'b1)) begin n_err++; $display("FAIL rnd%0d_keyed: got %h want %h", t, o1, ref_round(st, ky, 1'b1)); end
      n_vec++; if (o0 !== ref_round(st, ky, 1'b0)) begin n_err++; $display("FAIL rnd%0d_unkeyed: got %h want %h", t, o0, ref_round(st, ky, 1'b0)); end
      n_vec++; if (l1 !== lst || l0 !== lst) begin n_err++; $display("FAIL rnd%0d_last: got %b/%b want %b", t, l1, l0, lst); end
      n_vec++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, EXP_LAT); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_state = 128'd0; in_key = 128'd0; in_last = 1'b0; out_ready = 1'b0;
    build_tab();
    test_reset();
    test_fips();
    test_zero();
    test_63();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
